keccak_seq_ctrl: RTL
====================

# keccak_seq_ctrl

Sequencer that streams a message from the accelerator-local dual-port RAM into the Keccak coprocessor, signals the final block, waits for the permutation, and writes the squeezed digest back to RAM. It sits between the accelerator's register/start logic and the `keccak` core. It owns both RAM ports while busy: ports A and B are read as a 64-bit pair during absorb and written as a pair during squeeze.

## Interface
Parameters:
- ADDR_WIDTH, 32, RAM address width (32-bit word addressed)
- DATA_WIDTH, 32, RAM data width; fixed at 32
- OUT_MAX_WORDS, 17, maximum digest length in 64-bit words

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  level; sampled only in IDLE
- msg_base  in  ADDR_WIDTH  RAM word address of message word 0
- msg_len  in  16  message length in 64-bit words
- out_base  in  ADDR_WIDTH  RAM word address for digest word 0
- out_len  in  5  digest length in 64-bit words
- busy  out  1  high from START through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- error  out  1  one-cycle pulse on rejected start
- mem_en_a, mem_we_a, mem_en_b, mem_we_b  out  1 each  port enables and write enables
- mem_addr_a, mem_addr_b  out  ADDR_WIDTH  port addresses
- mem_wdata_a, mem_wdata_b  out  32  write data
- mem_be_a, mem_be_b  out  4  byte enables
- mem_rdata_a, mem_rdata_b  in  32  read data, valid 1 cycle after a read enable
- k_start  out  1  core init pulse
- k_din  out  64  absorb word
- k_din_valid  out  1  absorb word valid
- k_buffer_full  in  1  core cannot accept a word this cycle
- k_last_block  out  1  final-block pulse
- k_ready  in  1  permutation finished, squeeze data available
- k_dout  in  64  squeeze word
- k_dout_valid  in  1  squeeze word valid

## Operation
- States: IDLE, START, FETCH, LOAD, PUSH, LAST, WAIT_RDY, SQUEEZE, DONE.
- IDLE: if start and (msg_len==0 or out_len==0 or out_len>OUT_MAX_WORDS), pulse error for 1 cycle and stay in IDLE. If start and the lengths are valid, latch all four config inputs, clear idx and jdx, and go to START.
- START: k_start=1 for one cycle, then FETCH.
- FETCH: mem_en_a=mem_en_b=1, we=0, mem_addr_a=msg_base+2·idx, mem_addr_b=that address+1. Go to LOAD.
- LOAD: din_q <= {mem_rdata_b, mem_rdata_a}, so port A carries the low half. Go to PUSH.
- PUSH: k_din_valid=1, k_din=din_q, held stable while k_buffer_full=1. A word is accepted when k_din_valid and !k_buffer_full. On acceptance, idx++. Next state is FETCH if idx+1<msg_len, else LAST.
- LAST: k_last_block=1 for one cycle, then WAIT_RDY.
- WAIT_RDY: wait for k_ready=1, then SQUEEZE. k_dout_valid is ignored here; the core never asserts it before the cycle after k_ready.
- SQUEEZE: on each k_dout_valid, write in the same cycle with mem_en=we=1 on both ports:
  - mem_addr_a=out_base+2·jdx, mem_wdata_a=k_dout[31:0]
  - mem_addr_b=that address+1, mem_wdata_b=k_dout[63:32]
  - then jdx++; go to DONE when jdx+1==out_len.
- DONE: done=1 for one cycle, then IDLE. Further k_dout_valid is ignored.
- start while busy is ignored. Config inputs are used only as latched at start.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- mem_be_a = mem_be_b = 4'hF whenever the matching enable is high.

## Timing
- Reset: all outputs 0, including mem_*, k_*, busy, done and error. State=IDLE, idx=jdx=0, din_q=0. Reset mid-operation aborts in the same edge with no completion pulse. It is the caller's job to reset the core too.
- Outputs that are not asserted by the current state are driven 0. There are no latches.
- Start latency: start high in cycle 0 (IDLE) gives k_start in cycle 1, read in cycle 2, first k_din_valid in cycle 4.
- Absorb throughput: 3 cycles per word with no backpressure, plus 1 cycle per k_buffer_full stall cycle.
- k_last_block is asserted the cycle after the final acceptance.
- Write latency: 0; the RAM write happens in the same cycle as k_dout_valid.
- done comes the cycle after the final digest write.

## Test plan
- msg_len=1, out_len=1, base 0x00/0x40, RAM[0]=0x11111111, RAM[1]=0x22222222 -> k_din=0x22222222_11111111 in cycle 4; k_last_block in cycle 5; k_dout=0xAABBCCDD_EEFF0011 -> RAM[0x40]=0xEEFF0011, RAM[0x41]=0xAABBCCDD; done pulses exactly once.
- msg_len=3 with k_buffer_full held high 5 cycles on word 1 -> k_din stable during the stall; exactly 3 acceptances in order; total absorb cycles = 9+5.
- out_len=4 with gaps between k_dout_valid -> 8 RAM writes at out_base..out_base+7, in order; extra dout_valid pulses after done cause no writes.
- start with msg_len=0, then with out_len=18 -> error pulse each time; busy stays 0; no k_start; no RAM access.
- rst_n low for 1 cycle during WAIT_RDY -> next cycle all outputs 0 and state IDLE; a new start runs to completion normally.
- msg_base=0xFFFFFFFF, msg_len=1 -> mem_addr_a=0xFFFFFFFF, mem_addr_b=0x00000000; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/keccak_seq_ctrl.sv
// keccak_seq_ctrl
// Streams a message from the dual-port RAM into the Keccak core and writes the
// squeezed digest back. Ports A/B form one 64-bit lane: A = low half, B = high.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_start, i_msg_base/len,
//   i_out_base/len                 job request (config latched on accepted start)
//   o_busy, o_done, o_error        status (done/error are 1-cycle pulses)
//   o_mem_* / i_mem_rdata_*        RAM ports A and B
//   o_k_* / i_k_*                  Keccak core handshake
module keccak_seq_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OUT_MAX_WORDS = 17
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_msg_base,
    input  logic [15:0]             i_msg_len,
    input  logic [ADDR_WIDTH-1:0]   i_out_base,
    input  logic [4:0]              i_out_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic                    o_mem_en_a,
    output logic                    o_mem_we_a,
    output logic                    o_mem_en_b,
    output logic                    o_mem_we_b,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr_a,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr_b,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata_a,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata_b,
    output logic [3:0]              o_mem_be_a,
    output logic [3:0]              o_mem_be_b,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata_a,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata_b,
    output logic                    o_k_start,
    output logic [2*DATA_WIDTH-1:0] o_k_din,
    output logic                    o_k_din_valid,
    input  logic                    i_k_buffer_full,
    output logic                    o_k_last_block,
    input  logic                    i_k_ready,
    input  logic [2*DATA_WIDTH-1:0] i_k_dout,
    input  logic                    i_k_dout_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_FETCH, S_LOAD, S_PUSH, S_LAST, S_WAIT_RDY, S_SQUEEZE, S_DONE
    } state_t;

    localparam logic [5:0] LP_OUT_MAX = 6'(OUT_MAX_WORDS);

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_msg_base, r_out_base;
    logic [15:0]             r_msg_len, r_idx;
    logic [4:0]              r_out_len, r_jdx;
    logic [2*DATA_WIDTH-1:0] r_din;
    logic                    r_error;

    logic                    w_cfg_bad, w_go, w_accept, w_more, w_wr, w_jdx_last;
    logic [ADDR_WIDTH-1:0]   w_rd_addr, w_wr_addr;

    assign w_cfg_bad  = (i_msg_len == 16'd0) || (i_out_len == 5'd0) ||
                        ({1'b0, i_out_len} > LP_OUT_MAX);
    assign w_go       = (r_state == S_IDLE) && i_start && !w_cfg_bad;
    assign w_accept   = (r_state == S_PUSH) && !i_k_buffer_full;
    // 17-bit compare so idx+1 cannot wrap when msg_len is 0xFFFF
    assign w_more     = ({1'b0, r_idx} + 17'd1) < {1'b0, r_msg_len};
    assign w_wr       = (r_state == S_SQUEEZE) && i_k_dout_valid;
    assign w_jdx_last = (r_jdx + 5'd1) == r_out_len;
    // Word addresses wrap silently modulo 2^ADDR_WIDTH
    assign w_rd_addr  = r_msg_base + ADDR_WIDTH'({r_idx, 1'b0});
    assign w_wr_addr  = r_out_base + ADDR_WIDTH'({r_jdx, 1'b0});

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_go) w_next = S_START;
            S_START:    w_next = S_FETCH;
            S_FETCH:    w_next = S_LOAD;
            S_LOAD:     w_next = S_PUSH;
            S_PUSH:     if (w_accept) w_next = w_more ? S_FETCH : S_LAST;
            S_LAST:     w_next = S_WAIT_RDY;
            S_WAIT_RDY: if (i_k_ready) w_next = S_SQUEEZE;
            S_SQUEEZE:  if (w_wr && w_jdx_last) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Outputs: everything not owned by the current state is held at 0
    always_comb begin
        o_busy         = 1'b0;
        o_done         = 1'b0;
        o_mem_en_a     = 1'b0;
        o_mem_we_a     = 1'b0;
        o_mem_en_b     = 1'b0;
        o_mem_we_b     = 1'b0;
        o_mem_addr_a   = '0;
        o_mem_addr_b   = '0;
        o_mem_wdata_a  = '0;
        o_mem_wdata_b  = '0;
        o_mem_be_a     = 4'h0;
        o_mem_be_b     = 4'h0;
        o_k_start      = 1'b0;
        o_k_din        = '0;
        o_k_din_valid  = 1'b0;
        o_k_last_block = 1'b0;
        case (r_state)
            S_START: begin
                o_busy    = 1'b1;
                o_k_start = 1'b1;
            end
            S_FETCH: begin
                o_busy       = 1'b1;
                o_mem_en_a   = 1'b1;
                o_mem_en_b   = 1'b1;
                o_mem_be_a   = 4'hF;
                o_mem_be_b   = 4'hF;
                o_mem_addr_a = w_rd_addr;
                o_mem_addr_b = w_rd_addr + ADDR_WIDTH'(1);
            end
            S_LOAD, S_WAIT_RDY: o_busy = 1'b1;
            S_PUSH: begin
                o_busy        = 1'b1;
                o_k_din_valid = 1'b1;
                o_k_din       = r_din;
            end
            S_LAST: begin
                o_busy         = 1'b1;
                o_k_last_block = 1'b1;
            end
            S_SQUEEZE: begin
                o_busy = 1'b1;
                // Zero-latency write: the digest word goes to RAM in the same cycle
                if (i_k_dout_valid) begin
                    o_mem_en_a    = 1'b1;
                    o_mem_we_a    = 1'b1;
                    o_mem_en_b    = 1'b1;
                    o_mem_we_b    = 1'b1;
                    o_mem_be_a    = 4'hF;
                    o_mem_be_b    = 4'hF;
                    o_mem_addr_a  = w_wr_addr;
                    o_mem_addr_b  = w_wr_addr + ADDR_WIDTH'(1);
                    o_mem_wdata_a = i_k_dout[DATA_WIDTH-1:0];
                    o_mem_wdata_b = i_k_dout[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latched config, word counters, absorb buffer, error pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_msg_base <= '0;
            r_out_base <= '0;
            r_msg_len  <= '0;
            r_out_len  <= '0;
            r_idx      <= '0;
            r_jdx      <= '0;
            r_din      <= '0;
            r_error    <= 1'b0;
        end else begin
            // Registered so the pulse is glitch-free and zero out of reset
            r_error <= (r_state == S_IDLE) && i_start && w_cfg_bad;
            if (w_go) begin
                r_msg_base <= i_msg_base;
                r_out_base <= i_out_base;
                r_msg_len  <= i_msg_len;
                r_out_len  <= i_out_len;
                r_idx      <= '0;
                r_jdx      <= '0;
            end
            if (r_state == S_LOAD) r_din <= {i_mem_rdata_b, i_mem_rdata_a};
            if (w_accept)          r_idx <= r_idx + 16'd1;
            if (w_wr)              r_jdx <= r_jdx + 5'd1;
        end
    end

    assign o_error = r_error;

endmodule
